// File: rtl/pid_wb_master.sv
// pid_wb_master: Wishbone classic master that programs the PID slave's gain
// and setpoint registers and, for every process-variable sample, writes the
// sample and reads back the control output.
// Optional ack watchdog: define PID_WB_MASTER_TIMEOUT_EN to enable it.
module pid_wb_master #(
   parameter logic [15:0] ADR_KP  = 16'h0000,
   parameter logic [15:0] ADR_KI  = 16'h0004,
   parameter logic [15:0] ADR_KD  = 16'h0008,
   parameter logic [15:0] ADR_SP  = 16'h000C,
   parameter logic [15:0] ADR_PV  = 16'h0010,
   parameter logic [15:0] ADR_UN  = 16'h0018,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cfg_load,
   input  logic [31:0] i_kp,
   input  logic [31:0] i_ki,
   input  logic [31:0] i_kd,
   input  logic [31:0] i_sp,
   input  logic        i_pv_valid,
   input  logic [31:0] i_pv,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [15:0] o_wb_adr,
   output logic [31:0] o_wb_data,
   input  logic        i_wb_ack,
   input  logic [31:0] i_wb_data,
   output logic [31:0] o_un,
   output logic        o_un_valid,
   output logic        o_busy,
   output logic        o_overrun,
   output logic        o_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CFG   = 3'd1,
      S_GAP   = 3'd2,
      S_PV_WR = 3'd3,
      S_UN_RD = 3'd4
   } state_t;

   state_t      state_q, state_d;
   state_t      last_q;          // bus state whose ack led into the current GAP
   logic [1:0]  cfg_idx_q;       // 0..3 -> KP, KI, KD, SP
   logic [31:0] kp_q, ki_q, kd_q, sp_q;
   logic [31:0] pv_q;
   logic [31:0] pend_pv_q;
   logic        pend_q;
   logic [31:0] un_q;
   logic        un_valid_q;
   logic        overrun_q;

   logic        bus_active;
   logic        ack_seen;
   logic        timeout_hit;
   logic        start_cfg;
   logic        start_pv;
   logic        pv_from_pend;
   logic        live_taken;

   // A request is on the bus in every non-IDLE, non-GAP state; ack only counts there.
   assign bus_active = (state_q == S_CFG) || (state_q == S_PV_WR) || (state_q == S_UN_RD);
   assign ack_seen   = bus_active && i_wb_ack;
   assign live_taken = start_pv && !pv_from_pend;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode: config beats samples, pending beats a live sample.
   // NOTE: every signal gets a default first so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      start_cfg    = 1'b0;
      start_pv     = 1'b0;
      pv_from_pend = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_cfg_load) begin
               start_cfg = 1'b1;
               state_d   = S_CFG;
            end else if (pend_q) begin
               start_pv     = 1'b1;
               pv_from_pend = 1'b1;
               state_d      = S_PV_WR;
            end else if (i_pv_valid) begin
               start_pv = 1'b1;
               state_d  = S_PV_WR;
            end
         end
         S_CFG, S_PV_WR, S_UN_RD: begin
            if (i_wb_ack)         state_d = S_GAP;
            else if (timeout_hit) state_d = S_IDLE;
         end
         S_GAP: begin
            case (last_q)
               S_CFG:   state_d = (cfg_idx_q == 2'd3) ? S_IDLE : S_CFG;
               S_PV_WR: state_d = S_UN_RD;
               default: state_d = S_IDLE;
            endcase
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencing bookkeeping: which transaction just finished and the config index.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_q    <= S_IDLE;
         cfg_idx_q <= 2'd0;
      end else begin
         if (start_cfg)
            cfg_idx_q <= 2'd0;
         else if (state_q == S_GAP && last_q == S_CFG && cfg_idx_q != 2'd3)
            cfg_idx_q <= cfg_idx_q + 2'd1;
         if (ack_seen)
            last_q <= state_q;
      end
   end

   // Config values are frozen at CFG entry; loads during CFG are ignored.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         kp_q <= '0;
         ki_q <= '0;
         kd_q <= '0;
         sp_q <= '0;
      end else if (start_cfg) begin
         kp_q <= i_kp;
         ki_q <= i_ki;
         kd_q <= i_kd;
         sp_q <= i_sp;
      end
   end

   // Sample latch and single-entry pending buffer (newest sample wins).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pv_q      <= '0;
         pend_pv_q <= '0;
         pend_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (start_pv)
            pv_q <= pv_from_pend ? pend_pv_q : i_pv;
         if (i_pv_valid && !live_taken) begin
            pend_pv_q <= i_pv;
            pend_q    <= 1'b1;
            overrun_q <= pend_q && !pv_from_pend;
         end else if (pv_from_pend) begin
            pend_q <= 1'b0;
         end
      end
   end

   // Control output capture on the readback ack.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         un_q       <= '0;
         un_valid_q <= 1'b0;
      end else begin
         un_valid_q <= 1'b0;
         if (ack_seen && state_q == S_UN_RD) begin
            un_q       <= i_wb_data;
            un_valid_q <= 1'b1;
         end
      end
   end

   // Bus request decode; fields come straight from registered state so they hold until ack.
   always_comb begin
      o_wb_we   = 1'b0;
      o_wb_adr  = '0;
      o_wb_data = '0;
      case (state_q)
         S_CFG: begin
            o_wb_we = 1'b1;
            case (cfg_idx_q)
               2'd0:    begin o_wb_adr = ADR_KP; o_wb_data = kp_q; end
               2'd1:    begin o_wb_adr = ADR_KI; o_wb_data = ki_q; end
               2'd2:    begin o_wb_adr = ADR_KD; o_wb_data = kd_q; end
               default: begin o_wb_adr = ADR_SP; o_wb_data = sp_q; end
            endcase
         end
         S_PV_WR: begin
            o_wb_we   = 1'b1;
            o_wb_adr  = ADR_PV;
            o_wb_data = pv_q;
         end
         S_UN_RD: o_wb_adr = ADR_UN;
         default: ;
      endcase
   end

`ifdef PID_WB_MASTER_TIMEOUT_EN
   logic [31:0] to_cnt_q;
   logic        err_q;

   // Abandon after TIMEOUT consecutive request cycles without ack.
   assign timeout_hit = bus_active && !i_wb_ack && (to_cnt_q == TIMEOUT - 1);

   // Ack watchdog counter and sticky error flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (!bus_active || i_wb_ack || timeout_hit) to_cnt_q <= '0;
         else                                        to_cnt_q <= to_cnt_q + 32'd1;
         if (timeout_hit) err_q <= 1'b1;
      end
   end

   assign o_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign o_err       = 1'b0;
`endif

   assign o_wb_cyc   = bus_active;
   assign o_wb_stb   = bus_active;
   assign o_un       = un_q;
   assign o_un_valid = un_valid_q;
   assign o_busy     = (state_q != S_IDLE);
   assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_pid_wb_master.sv
// tb_pid_wb_master: directed and randomized checks of pid_wb_master against a
// transaction-level model (expected bus transaction list and latencies).
module tb_pid_wb_master;

   localparam logic [15:0] ADR_KP = 16'h0000;
   localparam logic [15:0] ADR_KI = 16'h0004;
   localparam logic [15:0] ADR_KD = 16'h0008;
   localparam logic [15:0] ADR_SP = 16'h000C;
   localparam logic [15:0] ADR_PV = 16'h0010;
   localparam logic [15:0] ADR_UN = 16'h0018;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_cfg_load;
   logic [31:0] i_kp, i_ki, i_kd, i_sp;
   logic        i_pv_valid;
   logic [31:0] i_pv;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [15:0] o_wb_adr;
   logic [31:0] o_wb_data;
   logic        i_wb_ack = 1'b0;
   logic [31:0] i_wb_data;
   logic [31:0] o_un;
   logic        o_un_valid, o_busy, o_overrun, o_err;

   pid_wb_master #(.TIMEOUT(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_cfg_load(i_cfg_load),
      .i_kp(i_kp), .i_ki(i_ki), .i_kd(i_kd), .i_sp(i_sp),
      .i_pv_valid(i_pv_valid), .i_pv(i_pv),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_adr(o_wb_adr), .o_wb_data(o_wb_data),
      .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
      .o_un(o_un), .o_un_valid(o_un_valid), .o_busy(o_busy),
      .o_overrun(o_overrun), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [15:0] adr;
      logic        we;
      logic [31:0] data;
      int          gap;
   } txn_t;

   txn_t log_q[$];
   txn_t exp_q[$];
   int   log_rd = 0;

   int          checks = 0;
   int          errors = 0;
   int          slave_wait = 0;
   bit          slave_hang = 1'b0;
   logic [31:0] slave_un = '0;
   int          unstable = 0;
   int          ovr_cnt = 0;

   assign i_wb_data = slave_un;

   // Slave model: acks after slave_wait wait states, logs every completed transaction.
   int          wc = 0;
   bit          in_txn = 1'b0;
   int          idle_run = 100;
   txn_t        cur;
   always @(negedge i_clk) begin
      if (o_wb_cyc !== 1'b1) begin
         i_wb_ack = 1'b0;
         wc       = 0;
         in_txn   = 1'b0;
         idle_run = idle_run + 1;
      end else begin
         if (!in_txn) begin
            in_txn   = 1'b1;
            cur.adr  = o_wb_adr;
            cur.we   = o_wb_we;
            cur.data = o_wb_data;
            cur.gap  = idle_run;
         end else if (o_wb_adr !== cur.adr || o_wb_we !== cur.we || o_wb_data !== cur.data) begin
            unstable = unstable + 1;
         end
         if (slave_hang) begin
            i_wb_ack = 1'b0;
         end else if (wc < slave_wait) begin
            wc       = wc + 1;
            i_wb_ack = 1'b0;
         end else begin
            i_wb_ack = 1'b1;
            if (!cur.we) cur.data = slave_un;
            log_q.push_back(cur);
            wc       = 0;
            in_txn   = 1'b0;
            idle_run = 0;
         end
      end
   end

   // Overrun pulse counter.
   always @(negedge i_clk) begin
      if (o_overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
   end

   // Global safety net.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required finish before 2000000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic pulse_pv(input logic [31:0] v);
      i_pv       = v;
      i_pv_valid = 1'b1;
      tick();
      i_pv_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (o_un_valid !== 1'b1 && n < 200) begin
         tick();
         n = n + 1;
      end
   endtask

   task automatic exp_push(input logic [15:0] adr, input logic we, input logic [31:0] data);
      txn_t t;
      t.adr  = adr;
      t.we   = we;
      t.data = data;
      t.gap  = 1;
      exp_q.push_back(t);
   endtask

   task automatic exp_cfg(input logic [31:0] kp, ki, kd, sp);
      exp_push(ADR_KP, 1'b1, kp);
      exp_push(ADR_KI, 1'b1, ki);
      exp_push(ADR_KD, 1'b1, kd);
      exp_push(ADR_SP, 1'b1, sp);
   endtask

   task automatic exp_sample(input logic [31:0] pv, input logic [31:0] un);
      exp_push(ADR_PV, 1'b1, pv);
      exp_push(ADR_UN, 1'b0, un);
   endtask

   task automatic check_log(input string tag);
      check({tag, "_len"}, log_q.size() - log_rd, exp_q.size());
      for (int i = 0; i < exp_q.size() && log_rd + i < log_q.size(); i++) begin
         check({tag, "_adr"},  log_q[log_rd+i].adr,  exp_q[i].adr);
         check({tag, "_we"},   log_q[log_rd+i].we,   exp_q[i].we);
         check({tag, "_data"}, log_q[log_rd+i].data, exp_q[i].data);
         check({tag, "_gap"},  log_q[log_rd+i].gap >= 1, 1);
      end
      log_rd = log_q.size();
      exp_q.delete();
   endtask

   initial begin
      int          n;
      int          w;
      int          ovr0;
      logic [31:0] pv, un;

      i_rst = 1'b1; i_cfg_load = 1'b0; i_pv_valid = 1'b0; i_pv = '0;
      i_kp = '0; i_ki = '0; i_kd = '0; i_sp = '0;
      tick(); tick();
      i_rst = 1'b0;

      // Reset then idle: everything quiet for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         check("idle_bus",   {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr}, 32'd0);
         check("idle_data",  o_wb_data, 32'd0);
         check("idle_un",    o_un, 32'd0);
         check("idle_flags", {o_un_valid, o_busy, o_overrun, o_err}, 32'd0);
         tick();
      end

      // Config load, zero-wait slave: 8 busy cycles, 4 writes in order.
      slave_wait = 0;
      i_kp = 32'd1; i_ki = 32'd2; i_kd = 32'd3; i_sp = 32'd100;
      i_cfg_load = 1'b1;
      tick();
      i_cfg_load = 1'b0;
      n = 0;
      while (o_busy === 1'b1 && n < 100) begin
         n = n + 1;
         tick();
      end
      check("cfg_busy_cycles", n, 8);
      exp_cfg(32'd1, 32'd2, 32'd3, 32'd100);
      check_log("cfg");

      // Sample 0x55 with two wait states: o_un_valid 8 cycles after the pulse.
      slave_wait = 2;
      slave_un   = 32'h1234;
      pulse_pv(32'h55);
      wait_valid(n);
      check("pv2_latency", 1 + n, 8);
      check("pv2_valid", o_un_valid, 1'b1);
      check("pv2_un", o_un, 32'h1234);
      check("pv2_busy", o_busy, 1'b1);
      tick();
      check("pv2_valid_pulse", o_un_valid, 1'b0);
      check("pv2_idle", o_busy, 1'b0);
      exp_sample(32'h55, 32'h1234);
      check_log("pv2");

      // Randomized samples: latency 4 + 2 per wait state, readback value passed through.
      for (int k = 0; k < 6; k++) begin
         w  = $urandom_range(0, 3);
         pv = $urandom;
         un = $urandom;
         slave_wait = w;
         slave_un   = un;
         pulse_pv(pv);
         wait_valid(n);
         check("rnd_latency", 1 + n, 4 + 2 * w);
         check("rnd_valid", o_un_valid, 1'b1);
         check("rnd_un", o_un, un);
         tick();
         check("rnd_valid_pulse", o_un_valid, 1'b0);
         exp_sample(pv, un);
         check_log("rnd");
      end

      // Three samples during one transaction: one overrun, newest pending sample wins.
      slave_wait = 3;
      slave_un   = 32'hCAFE_0001;
      ovr0 = ovr_cnt;
      pulse_pv(32'd10);
      pulse_pv(32'd20);
      pulse_pv(32'd30);
      wait_valid(n);
      check("ovr_first_valid", o_un_valid, 1'b1);
      tick();
      wait_valid(n);
      check("ovr_second_valid", o_un_valid, 1'b1);
      check("ovr_un", o_un, 32'hCAFE_0001);
      tick();
      check("ovr_count", ovr_cnt - ovr0, 1);
      exp_sample(32'd10, 32'hCAFE_0001);
      exp_sample(32'd30, 32'hCAFE_0001);
      check_log("ovr");

      // Config and sample in the same cycle: config sequence first, then the sample.
      slave_wait = 1;
      slave_un   = 32'h0BAD_F00D;
      i_kp = 32'h11; i_ki = 32'h22; i_kd = 32'h33; i_sp = 32'h44;
      i_pv = 32'h77;
      i_cfg_load = 1'b1;
      i_pv_valid = 1'b1;
      tick();
      i_cfg_load = 1'b0;
      i_pv_valid = 1'b0;
      wait_valid(n);
      check("both_valid", o_un_valid, 1'b1);
      check("both_un", o_un, 32'h0BAD_F00D);
      tick();
      exp_cfg(32'h11, 32'h22, 32'h33, 32'h44);
      exp_sample(32'h77, 32'h0BAD_F00D);
      check_log("both");

`ifdef PID_WB_MASTER_TIMEOUT_EN
      // Watchdog: slave never acks, request abandoned after 8 cycles, sticky error.
      slave_hang = 1'b1;
      pulse_pv(32'h99);
      n = 0;
      while (o_wb_cyc === 1'b1 && n < 100) begin
         n = n + 1;
         tick();
      end
      check("to_cyc_cycles", n, 8);
      check("to_err", o_err, 1'b1);
      check("to_no_valid", o_un_valid, 1'b0);
      tick(); tick(); tick();
      check("to_err_sticky", o_err, 1'b1);
      check("to_idle", o_busy, 1'b0);
      slave_hang = 1'b0;
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check("to_err_cleared", o_err, 1'b0);
      check_log("to");
`else
      check("err_tied", o_err, 1'b0);
`endif

      // Reset mid-transaction with a pending sample: bus drops, state and output cleared.
      slave_wait = 6;
      pulse_pv(32'hAA);
      tick();
      pulse_pv(32'hBB);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check("rst_cyc", o_wb_cyc, 1'b0);
      check("rst_un", o_un, 32'd0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_err", o_err, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("rst_no_pending", {o_wb_cyc, o_busy}, 32'd0);
         tick();
      end
      check_log("rst");

      check("bus_stable", unstable, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
